// File: rtl/stream_mux_4to1_rr.sv
// Four-channel to one stream merger with round-robin arbitration and a single
// registered output stage; out_sel carries the source channel index.
module stream_mux_4to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic [WIDTH-1:0] in1_data,
  input  logic [WIDTH-1:0] in2_data,
  input  logic [WIDTH-1:0] in3_data,
  input  logic             in0_valid,
  input  logic             in1_valid,
  input  logic             in2_valid,
  input  logic             in3_valid,
  output logic             in0_ready,
  output logic             in1_ready,
  output logic             in2_ready,
  output logic             in3_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            vld;
  logic [NUM_LANES-1:0]            rdy;
  logic [NUM_LANES-1:0][WIDTH-1:0] dat;
  logic [1:0]                      ptr;
  logic [1:0]                      gnt;
  logic                            gnt_vld;
  logic                            load_en;
  logic                            take;

  assign vld = {in3_valid, in2_valid, in1_valid, in0_valid};
  assign dat = {in3_data, in2_data, in1_data, in0_data};

  assign load_en = ~out_valid | out_ready;

  // Scan from the farthest candidate down so the one closest to ptr wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt     = ptr;
    idx     = ptr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (vld[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_rdy
    assign rdy[k] = load_en & gnt_vld & (gnt == 2'(k)) & ~rst;
  end

  assign {in3_ready, in2_ready, in1_ready, in0_ready} = rdy;
  assign take = |rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= dat[gnt];
      out_sel   <= gnt;
      ptr       <= gnt + 2'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
